// File: rtl/gs_cfg_pager_if.sv
// Z80-side bus bundle for gs_cfg_pager: strobes, address selects, data in and read-back.
interface gs_cfg_pager_if;
  logic       iorq_n;
  logic       mreq_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] pa;
  logic [1:0] ahi;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;

  modport master (
    output iorq_n, mreq_n, rd_n, wr_n, pa, ahi, din,
    input  dout, dout_en
  );

  modport slave (
    input  iorq_n, mreq_n, rd_n, wr_n, pa, ahi, din,
    output dout, dout_en
  );
endinterface

// File: rtl/gs_cfg_pager.sv
// Single-clock NeoGS FPGA-config sequencer, 4-window memory pager and counted warm reset.
// Z80 port writes are synchronised into clkin; reads and paging stay combinational.
module gs_cfg_pager #(
  parameter int unsigned PAGE_BITS   = 2,
  parameter int unsigned NCFG_LOW    = 8,
  parameter int unsigned CFG_TIMEOUT = 4096,
  parameter int unsigned RST_CYCLES  = 16
) (
  input  logic                 i_clkin,
  input  logic                 i_coldres,
  gs_cfg_pager_if.slave        io_z80,
  output logic [PAGE_BITS-1:0] o_mema,
  output logic                 o_romcs_n,
  output logic                 o_ramcs_n,
  output logic                 o_memoe_n,
  output logic                 o_memwe_n,
  output logic                 o_drive_en,
  output logic                 o_fpga_cs,
  output logic                 o_config_n,
  input  logic                 i_status_n,
  input  logic                 i_conf_done,
  input  logic                 i_init_done,
  output logic                 o_warmres_n,
  output logic                 o_busy
);
  localparam int unsigned CntMax = (CFG_TIMEOUT > NCFG_LOW) ? CFG_TIMEOUT : NCFG_LOW;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam int unsigned WcntW  = $clog2(RST_CYCLES + 1);
  localparam logic [CntW-1:0]  NcfgLoad = CntW'(NCFG_LOW - 1);
  localparam logic [CntW-1:0]  TmoLoad  = CntW'(CFG_TIMEOUT - 1);
  localparam logic [WcntW-1:0] WarmLoad = WcntW'(RST_CYCLES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StNcfg  = 3'd1,
    StWstat = 3'd2,
    StWdone = 3'd3,
    StWinit = 3'd4,
    StDone  = 3'd5,
    StError = 3'd6
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [CntW-1:0]      r_cnt, w_cnt_nxt;
  logic [WcntW-1:0]     r_wcnt;
  logic [2:0]           r_wr_sync;
  logic [1:0]           r_stat_sync, r_cdone_sync, r_idone_sync;
  logic [7:0]           r_cap_d;
  logic [1:0]           r_cap_pa;
  logic                 r_commit;
  logic                 r_was_cold_n;
  logic [PAGE_BITS-1:0] r_page [4];
  logic [3:0]           r_ram;

  logic w_wr_qual, w_wr_rise, w_status_s, w_cdone_s, w_idone_s;
  logic w_cmd_page, w_cmd_ctrl, w_idle_like, w_start, w_warm_req, w_done_entry, w_err;
  logic w_unused_cap;

  assign w_wr_qual  = ~io_z80.iorq_n & ~io_z80.wr_n & (io_z80.pa != 2'b00);
  assign w_wr_rise  = r_wr_sync[1] & ~r_wr_sync[2];
  assign w_status_s = r_stat_sync[1];
  assign w_cdone_s  = r_cdone_sync[1];
  assign w_idone_s  = r_idone_sync[1];

  always_ff @(posedge i_clkin or posedge i_coldres) begin
    if (i_coldres) begin
      r_wr_sync    <= '0;
      r_stat_sync  <= '0;
      r_cdone_sync <= '0;
      r_idone_sync <= '0;
      r_cap_d      <= '0;
      r_cap_pa     <= '0;
      r_commit     <= 1'b0;
    end else begin
      r_wr_sync    <= {r_wr_sync[1:0], w_wr_qual};
      r_stat_sync  <= {r_stat_sync[0], i_status_n};
      r_cdone_sync <= {r_cdone_sync[0], i_conf_done};
      r_idone_sync <= {r_idone_sync[0], i_init_done};
      r_commit     <= w_wr_rise;
      // din/pa are stable by the time the synchronised edge arrives.
      if (w_wr_rise) begin
        r_cap_d  <= io_z80.din;
        r_cap_pa <= io_z80.pa;
      end
    end
  end

  assign w_unused_cap = ^r_cap_d;
  assign w_cmd_page   = r_commit & (r_cap_pa == 2'b01);
  assign w_cmd_ctrl   = r_commit & (r_cap_pa == 2'b10);
  assign w_idle_like  = (r_state == StIdle) | (r_state == StDone) | (r_state == StError);
  assign w_start      = w_cmd_ctrl & r_cap_d[0] & w_idle_like;
  // An accepted start defers the warm reset to DONE entry.
  assign w_warm_req   = w_cmd_ctrl & r_cap_d[1] & ~w_start;
  assign w_done_entry = (w_state_nxt == StDone) & (r_state != StDone);
  assign w_err        = (r_state == StError);

  always_ff @(posedge i_clkin or posedge i_coldres) begin
    if (i_coldres) begin
      for (int w = 0; w < 4; w++) r_page[w] <= PAGE_BITS'(w);
      r_ram <= '0;
    end else if (w_cmd_page && (r_cap_d[7:6] != 2'b00)) begin
      r_page[r_cap_d[7:6]] <= r_cap_d[PAGE_BITS-1:0];
      r_ram[r_cap_d[7:6]]  <= r_cap_d[5];
    end
  end

  always_ff @(posedge i_clkin or posedge i_coldres) begin
    if (i_coldres) begin
      r_was_cold_n <= 1'b0;
      r_wcnt       <= WarmLoad;
    end else begin
      if (w_cmd_ctrl && r_cap_d[7]) r_was_cold_n <= 1'b1;
      if (w_done_entry || w_warm_req) r_wcnt <= WarmLoad;
      else if (r_wcnt != '0)          r_wcnt <= r_wcnt - 1'b1;
    end
  end

  always_ff @(posedge i_clkin or posedge i_coldres) begin
    if (i_coldres) begin
      r_state <= StNcfg;
      r_cnt   <= NcfgLoad;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StNcfg: begin
        if (r_cnt == '0) begin
          w_state_nxt = StWstat;
          w_cnt_nxt   = TmoLoad;
        end else w_cnt_nxt = r_cnt - 1'b1;
      end
      StWstat: begin
        if (w_status_s) begin
          w_state_nxt = StWdone;
          w_cnt_nxt   = TmoLoad;
        end else if (r_cnt == '0) w_state_nxt = StError;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      StWdone: begin
        if (!w_status_s) w_state_nxt = StError;
        else if (w_cdone_s) begin
          w_state_nxt = StWinit;
          w_cnt_nxt   = TmoLoad;
        end else if (r_cnt == '0) w_state_nxt = StError;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      StWinit: begin
        if (w_idone_s) w_state_nxt = StDone;
        else if (r_cnt == '0) w_state_nxt = StError;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      default: ;
    endcase
    if (w_start) begin
      w_state_nxt = StNcfg;
      w_cnt_nxt   = NcfgLoad;
    end
  end

  always_comb begin
    io_z80.dout    = 8'h00;
    io_z80.dout_en = 1'b0;
    if (!io_z80.iorq_n && !io_z80.rd_n) begin
      if (io_z80.pa == 2'b01) begin
        io_z80.dout    = {r_was_cold_n, w_err, ~w_idle_like, 5'b0};
        io_z80.dout_en = 1'b1;
      end else if (io_z80.pa == 2'b10) begin
        io_z80.dout    = {w_status_s, w_cdone_s, w_idone_s, 2'b0, r_state};
        io_z80.dout_en = 1'b1;
      end
    end
  end

  assign o_mema      = r_page[io_z80.ahi];
  assign o_romcs_n   = r_ram[io_z80.ahi];
  assign o_ramcs_n   = ~r_ram[io_z80.ahi];
  assign o_memoe_n   = io_z80.mreq_n | io_z80.rd_n;
  assign o_memwe_n   = io_z80.mreq_n | io_z80.wr_n | ~r_ram[io_z80.ahi];
  assign o_fpga_cs   = (io_z80.pa == 2'b11) & ~io_z80.iorq_n;
  assign o_config_n  = (r_state != StNcfg);
  assign o_drive_en  = (r_state != StDone);
  assign o_busy      = ~w_idle_like;
  assign o_warmres_n = (r_wcnt == '0);
endmodule

// File: tb/tb_gs_cfg_pager.sv
// Self-checking bench for gs_cfg_pager: config sequencing, paging table, warm reset, cold reset.
module tb_gs_cfg_pager;
  localparam int unsigned PB   = 2;
  localparam int unsigned NCFG = 8;
  localparam int unsigned TMO  = 4096;
  localparam int unsigned RSTC = 16;

  logic clk = 1'b0;
  logic coldres;
  always #5 clk = ~clk;

  gs_cfg_pager_if bus ();

  logic [PB-1:0] mema;
  logic romcs_n, ramcs_n, memoe_n, memwe_n, drive_en, fpga_cs, config_n, warmres_n, busy;
  logic status_n = 1'b0, conf_done = 1'b0, init_done = 1'b0;

  gs_cfg_pager #(
    .PAGE_BITS  (PB),
    .NCFG_LOW   (NCFG),
    .CFG_TIMEOUT(TMO),
    .RST_CYCLES (RSTC)
  ) dut (
    .i_clkin    (clk),
    .i_coldres  (coldres),
    .io_z80     (bus),
    .o_mema     (mema),
    .o_romcs_n  (romcs_n),
    .o_ramcs_n  (ramcs_n),
    .o_memoe_n  (memoe_n),
    .o_memwe_n  (memwe_n),
    .o_drive_en (drive_en),
    .o_fpga_cs  (fpga_cs),
    .o_config_n (config_n),
    .i_status_n (status_n),
    .i_conf_done(conf_done),
    .i_init_done(init_done),
    .o_warmres_n(warmres_n),
    .o_busy     (busy)
  );

  // FPGA model: status_n 3 cycles after config_n rises, conf_done 20 later, init_done 5 later.
  logic fpga_stuck = 1'b0;
  int   since_cfg  = 0;
  always @(negedge clk) begin
    if (config_n !== 1'b1) begin
      since_cfg = 0;
      status_n  = 1'b0;
      conf_done = 1'b0;
      init_done = 1'b0;
    end else begin
      since_cfg = since_cfg + 1;
      status_n  = !fpga_stuck && since_cfg >= 3;
      conf_done = status_n && since_cfg >= 23;
      init_done = conf_done && since_cfg >= 28;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1'b1; bus.mreq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.pa = 2'b00; bus.ahi = 2'b00; bus.din = 8'h00;
  endtask

  task automatic io_write(input logic [1:0] p, input logic [7:0] d);
    @(negedge clk);
    bus.pa = p; bus.din = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1; bus.pa = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic io_read(input logic [1:0] p, output logic [7:0] d, output logic en);
    bus.pa = p; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    #1;
    d  = bus.dout;
    en = bus.dout_en;
    bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.pa = 2'b00;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    logic [7:0] d;
    logic       en;
    d = 8'h00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      io_read(2'b10, d, en);
      if (d[2:0] == s) break;
    end
    check(name, {29'd0, d[2:0]}, {29'd0, s});
  endtask

  typedef struct {
    logic [7:0]    din;
    logic [1:0]    ahi;
    logic [PB-1:0] mema;
    logic          ram;
  } page_vec_t;

  page_vec_t vecs[7];
  page_vec_t sb[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       en;
    int         n;
    int         lows;
    page_vec_t  e;

    vecs[0] = '{8'hE3, 2'd3, 2'd3, 1'b1};
    vecs[1] = '{8'h01, 2'd0, 2'd0, 1'b0};
    vecs[2] = '{8'h23, 2'd0, 2'd0, 1'b0};
    vecs[3] = '{8'h92, 2'd2, 2'd2, 1'b0};
    vecs[4] = '{8'h61, 2'd1, 2'd1, 1'b1};
    vecs[5] = '{8'h7C, 2'd1, 2'd0, 1'b1};
    vecs[6] = '{8'h4A, 2'd1, 2'd2, 1'b0};

    bus_idle();
    coldres = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_config_n", config_n, 0);
    check("rst_warmres_n", warmres_n, 0);
    check("rst_drive_en", drive_en, 1);
    check("rst_dout_en_idle", bus.dout_en, 0);
    io_read(2'b10, d, en);
    check("rst_read_state", d, 8'h01);
    check("rst_read_en", en, 1);
    io_read(2'b01, d, en);
    check("rst_read_flags", d, 8'h20);
    for (int w = 0; w < 4; w++) begin
      bus.ahi = 2'(w);
      #1;
      check("rst_win_mema", mema, w % (1 << PB));
      check("rst_win_romcs", romcs_n, 0);
      check("rst_win_ramcs", ramcs_n, 1);
    end
    bus.ahi = 2'd0;

    // Cold boot.
    @(negedge clk);
    coldres = 1'b0;
    #1;
    n = 0;
    while (!config_n && n < 100) begin n++; @(negedge clk); #1; end
    check("boot_ncfg_low", n, NCFG);
    n = 0;
    while (drive_en && n < 300) begin @(negedge clk); #1; n++; end
    check("boot_drive_en_low", drive_en, 0);
    lows = 0;
    while (!warmres_n && lows < 100) begin lows++; @(negedge clk); #1; end
    check("boot_warm_len", lows, RSTC);
    io_read(2'b10, d, en);
    check("boot_read_done", d, 8'hE5);
    io_read(2'b01, d, en);
    check("boot_read_flags", d, 8'h00);

    // Page table via scoreboard.
    for (int i = 0; i < 7; i++) begin
      io_write(2'b01, vecs[i].din);
      sb.push_back(vecs[i]);
      bus.ahi = vecs[i].ahi; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
      #1;
      e = sb.pop_front();
      check("page_mema", mema, e.mema);
      check("page_ramcs", ramcs_n, !e.ram);
      check("page_romcs", romcs_n, e.ram);
      check("page_memoe", memoe_n, 0);
      bus.rd_n = 1'b1; bus.wr_n = 1'b0;
      #1;
      check("page_memwe", memwe_n, !e.ram);
      bus.mreq_n = 1'b1; bus.wr_n = 1'b1;
    end
    bus.ahi = 2'd3;
    #1;
    check("page_win3_kept", {mema, ramcs_n}, {2'd3, 1'b0});
    bus.pa = 2'b11; bus.iorq_n = 1'b0;
    #1;
    check("fpga_cs_on", fpga_cs, 1);
    bus.pa = 2'b10;
    #1;
    check("fpga_cs_off", fpga_cs, 0);
    bus_idle();

    // Start while busy is ignored.
    io_write(2'b10, 8'h01);
    wait_state(3'd3, 80, "reach_wdone");
    io_write(2'b10, 8'h01);
    io_read(2'b10, d, en);
    check("busy_start_ignored", (d[2:0] == 3'd3) || (d[2:0] == 3'd4), 1);
    check("busy_config_n_high", config_n, 1);
    io_write(2'b10, 8'h80);
    wait_state(3'd5, 200, "reach_done2");
    io_read(2'b01, d, en);
    check("was_cold_set", d, 8'h80);

    // Warm reset retrigger at 5 remaining.
    repeat (25) @(negedge clk);
    #1;
    check("warm_idle", warmres_n, 1);
    @(negedge clk);
    bus.pa = 2'b10; bus.din = 8'h02; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    n = 0;
    while (warmres_n && n < 20) begin @(negedge clk); #1; n++; end
    check("warm_req_low", warmres_n, 0);
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    lows = 0;
    for (int s = 0; s < 200 && !warmres_n; s++) begin
      if (s == 11) begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
      if (s == 13) begin bus.iorq_n = 1'b1; bus.wr_n = 1'b1; end
      lows++;
      @(negedge clk); #1;
    end
    check("warm_retrigger_len", (lows >= 30) && (lows <= 32), 1);
    bus_idle();

    // Stuck FPGA -> timeout in WSTAT -> ERROR, then restart.
    fpga_stuck = 1'b1;
    io_write(2'b10, 8'h01);
    wait_state(3'd2, 50, "reach_wstat");
    bus.pa = 2'b10; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    n = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (bus.dout[2:0] != 3'd2) break;
      n++;
    end
    check("wstat_timeout_len", n, TMO);
    check("error_state", bus.dout[2:0], 3'd6);
    bus_idle();
    #1;
    io_read(2'b01, d, en);
    check("error_flags", d, 8'hC0);
    check("error_drive_en", drive_en, 1);
    fpga_stuck = 1'b0;
    io_write(2'b10, 8'h01);
    io_read(2'b01, d, en);
    check("restart_err_clear", d, 8'hA0);
    wait_state(3'd5, 200, "reach_done3");

    // Cold reset in the middle of WDONE.
    io_write(2'b10, 8'h01);
    wait_state(3'd3, 80, "reach_wdone2");
    bus.ahi = 2'd3;
    coldres = 1'b1;
    #1;
    check("cold_config_n", config_n, 0);
    check("cold_warmres_n", warmres_n, 0);
    check("cold_win3", {mema, romcs_n, ramcs_n}, {2'd3, 1'b0, 1'b1});
    io_read(2'b01, d, en);
    check("cold_flags", d, 8'h20);
    @(negedge clk);
    coldres = 1'b0;
    #1;
    n = 0;
    while (!config_n && n < 100) begin n++; @(negedge clk); #1; end
    check("cold_ncfg_low", n, NCFG);
    wait_state(3'd5, 200, "cold_reach_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gs_cfg_pager.md
Name: gs_cfg_pager

Overview:
- Synchronous successor to the NeoGS CPLD FPGA-config and paging logic.
- Runs all Z80 port traffic through a single clock.
- Sequences FPGA configuration with timeouts and error reporting.
- Pages four 16K CPU windows into a parametrised ROM/RAM page space.
- Generates a counted warm reset.
- Sits between the Z80 bus, the memories and the ACEX1K config pins; the top level converts enables to tri-state.

Parameters:
PAGE_BITS, 2, page-number width per window (1..5); mema width.
NCFG_LOW, 8, clkin cycles nCONFIG is held low per configuration attempt (>=2).
CFG_TIMEOUT, 4096, cycles allowed in each wait state before ERROR.
RST_CYCLES, 16, warm-reset low time in clkin cycles.

Ports:
clkin  in  1  system clock.
coldres  in  1  asynchronous active-high reset.
iorq_n, mreq_n, rd_n, wr_n  in  1 each  Z80 strobes, asynchronous to clkin.
pa  in  2  {a7,a6} port select.
ahi  in  2  {a15,a14} window select.
din  in  8  Z80 data in.
dout  out  8  read data.
dout_en  out  1  drive dout onto Z80 bus.
mema  out  PAGE_BITS  memory page address.
romcs_n, ramcs_n, memoe_n, memwe_n  out  1 each  memory controls.
drive_en  out  1  1 = this block owns the memory/cs pins; 0 = top level tri-states them.
fpga_cs  out  1  FPGA chip select.
config_n  out  1  FPGA nCONFIG.
status_n, conf_done, init_done  in  1 each  FPGA status, 2-FF synchronised inside.
warmres_n  out  1  warm reset; 0 = asserted, 1 = release (open-drain at top).
busy  out  1  config FSM not in IDLE/DONE/ERROR.

Behaviour:
- Reset: coldres asynchronous and active-high; every flop clears on its assertion.
- Reset values:
  - state=NCFG, config_n=0, was_cold_n=0, drive_en=1, warmres_n=0.
  - Window w = ROM page w mod 2^PAGE_BITS.
  - Counters loaded; dout_en=0.
- Port writes:
  - Qualifier: iorq_n=0, wr_n=0, pa!=00.
  - Qualifier is 2-FF synchronised; din and pa are captured on the synchronised rising edge and committed one cycle later.
  - Effect is therefore 3-4 cycles after the strobe asserts.
  - One commit per strobe regardless of its length.
- pa=01 WR (page): din[7:6]=window, din[5]=RAM(1)/ROM(0), din[PAGE_BITS-1:0]=page. Window 0 is fixed ROM page 0; writes to it are ignored.
- pa=10 WR (control):
  - din[7]=1 sets was_cold_n (sticky until coldres).
  - din[0]=1 starts configuration; accepted only in IDLE/DONE/ERROR, ignored while busy.
  - din[1]=1 requests a warm reset.
  - d0 and d1 together: the start takes priority; the warm reset then occurs at DONE.
- Reads (combinational from synchronised-free qualifier iorq_n=0, rd_n=0):
  - pa=01: dout={was_cold_n,err,busy,5'b0}.
  - pa=10: dout={status_n_s,conf_done_s,init_done_s,2'b0,state[2:0]}.
  - dout_en=1 only for these reads; otherwise dout=0, dout_en=0.
- Paging (combinational on ahi):
  - Selected window gives mema and romcs_n/ramcs_n (exactly one low).
  - memoe_n=mreq_n|rd_n; memwe_n=mreq_n|wr_n|romsel (ROM never written).
- FPGA select: fpga_cs=(pa==11)&~iorq_n.
- Config FSM (state codes 0..6):
  - IDLE(0): wait for start.
  - NCFG(1): config_n=0 for NCFG_LOW cycles, then config_n=1, drive_en=1.
  - WSTAT(2): wait status_n_s=1.
  - WDONE(3): wait conf_done_s=1; status_n_s=0 -> ERROR.
  - WINIT(4): wait init_done_s=1.
  - DONE(5): drive_en=0, then start a warm reset.
  - ERROR(6): err=1, drive_en=1; cleared on the next start.
  - WSTAT, WDONE and WINIT each reload a CFG_TIMEOUT counter on entry; expiry -> ERROR.
  - After coldres the FSM starts in NCFG automatically.
- Warm reset:
  - Counter loaded with RST_CYCLES on coldres, on entry to DONE, or on a d1 request.
  - warmres_n=0 while the counter is nonzero; the counter decrements every cycle.
  - A retrigger mid-count reloads the counter; warmres_n=1 at 0.

Test Plan:
- Cold boot with an ideal FPGA model (status_n rising 3 cycles after config_n rises, conf_done after 20 cycles, init_done after 5): config_n low exactly 8 cycles; state reaches 5; drive_en falls; warmres_n low exactly 16 cycles after DONE entry.
- FPGA holds status_n=0: ERROR after 4096 cycles in WSTAT; read pa=10 returns state 6 with err=1. Writing 0x01 restarts NCFG and clears err.
- Page write 0xE3 (window 3, RAM, page 3), then ahi=11 with mreq_n=rd_n=0: mema=3, ramcs_n=0, romcs_n=1, memoe_n=0. Write 0x01 (window 0) leaves window 0 at ROM page 0.
- Control write 0x01 issued while busy (state 3): ignored, FSM unaffected. Write 0x80: the pa=01 read returns bit7=1.
- Write 0x02 during an active warm-reset count at 5 remaining: count reloads, giving 16 further low cycles.
- Assert coldres mid-WDONE: outputs immediately at reset values (config_n=0, warmres_n=0, window map default); NCFG restarts on release.
